bus_master_bridge: RTL and testbench

Single-outstanding bus master that converts CPU load/store requests into STB/WE bus cycles for memory-mapped peripherals such as the seven-segment display device. Sits directly upstream of the peripheral slaves: drives ADR_O/DAT_O/WE_O/STB_O, waits for ACK_I, captures DAT_I, and returns a one-cycle completion pulse to the CPU. An optional watchdog terminates cycles that a slave never acknowledges.

---
 rtl/bus_master_bridge.sv | 144 ++++++++++++++
 tb/tb_bus_master_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_bridge.sv
// Single-outstanding CPU-to-bus master: one STB/WE cycle per request.
// Optional watchdog abort enabled by defining BUS_TIMEOUT_EN.
module bus_master_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic        WE_O,
  output logic        STB_O,
  input  logic        ACK_I,
  input  logic [31:0] DAT_I
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_busy;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_rdata;
  logic        w_expire;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && cpu_req;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Expiry is judged in the last permitted STB cycle, before it ends
  assign w_expire = (r_state == S_BUS) && (r_cnt >= C_LAST);
  assign cpu_err  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == S_BUS && !ACK_I && r_cnt != C_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (r_state == S_BUS) begin
      if (ACK_I) begin
        r_err <= 1'b0;
      end else if (w_expire) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_expire = 1'b0;
  assign cpu_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (cpu_req) begin
            r_adr   <= cpu_addr;
            r_dat   <= cpu_wdata;
            r_we    <= cpu_we;
            r_stb   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          if (ACK_I) begin
            r_stb   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_RESP;
            if (!r_we) begin
              r_rdata <= DAT_I;
            end
          end else if (w_expire) begin
            r_stb   <= 1'b0;
            r_ready <= 1'b1;
            r_rdata <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_stb   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_ready = r_ready;
  assign cpu_busy  = r_busy;
  assign ADR_O     = r_adr;
  assign DAT_O     = r_dat;
  assign WE_O      = r_we;
  assign STB_O     = r_stb;

endmodule

// File: tb/tb_bus_master_bridge.sv
// Directed bench for bus_master_bridge with a wait-state slave model.
// Watchdog cases build only when BUS_TIMEOUT_EN is defined.
module tb_bus_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        cpu_busy;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic        WE_O;
  logic        STB_O;
  logic        ACK_I;
  logic [31:0] DAT_I;

  int          slv_waits = 0;
  logic [31:0] slv_data = '0;
  int          slv_cnt;
  int          stb_total = 0;
  int          rdy_total = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bus_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .WE_O(WE_O),
    .STB_O(STB_O), .ACK_I(ACK_I), .DAT_I(DAT_I)
  );

  // Slave acks once STB_O has been held for slv_waits extra cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) slv_cnt <= 0;
    else if (STB_O && !ACK_I) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end
  assign ACK_I = STB_O && (slv_cnt >= slv_waits);
  assign DAT_I = ACK_I ? slv_data : 32'h0BAD_0BAD;

  always @(posedge clk) begin
    if (STB_O) stb_total <= stb_total + 1;
    if (cpu_ready) rdy_total <= rdy_total + 1;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_stb;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [31:0] sdata, input int waits,
                              input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_stb);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.sdata = sdata;
    v.waits = waits; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.exp_stb = exp_stb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int s0, r0, lat;
    bit seen;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we;
    cpu_addr = v.addr; cpu_wdata = v.wdata;
    slv_waits = v.waits; slv_data = v.sdata;
    s0 = stb_total; r0 = rdy_total;
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = ~v.addr; cpu_wdata = ~v.wdata;
    cpu_we = ~v.we;
    chk({tag, " adr"}, ADR_O, v.addr);
    chk({tag, " dat"}, DAT_O, v.wdata);
    chk({tag, " we"}, {31'd0, WE_O}, {31'd0, v.we});
    chk({tag, " stb"}, {31'd0, STB_O}, 32'd1);
    chk({tag, " busy"}, {31'd0, cpu_busy}, 32'd1);
    lat = 1; seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_ready) seen = 1;
    end
    chk({tag, " ready seen"}, {31'd0, seen}, 32'd1);
    chk({tag, " latency"}, lat, v.exp_stb + 1);
    chk({tag, " rdata"}, cpu_rdata, v.exp_rdata);
    chk({tag, " err"}, {31'd0, cpu_err}, {31'd0, v.exp_err});
    chk({tag, " stb in resp"}, {31'd0, STB_O}, 32'd0);
    @(negedge clk);
    chk({tag, " ready pulse"}, {31'd0, cpu_ready}, 32'd0);
    chk({tag, " busy end"}, {31'd0, cpu_busy}, 32'd0);
    chk({tag, " stb cycles"}, stb_total - s0, v.exp_stb);
    chk({tag, " ready count"}, rdy_total - r0, 32'd1);
  endtask

  vec_t tbl[5];
  int   s0, r0;

  initial begin
    tbl[0] = mk(1'b1, 32'hFFFF_FE00, 32'h0000_1234, 32'h1111_1111,
                0, 32'h0, 1'b0, 1);
    tbl[1] = mk(1'b0, 32'hFFFF_FE04, 32'h0, 32'hCAFE_F00D,
                2, 32'hCAFE_F00D, 1'b0, 3);
    tbl[2] = mk(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 32'h2222_2222,
                1, 32'hCAFE_F00D, 1'b0, 2);
    tbl[3] = mk(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678,
                0, 32'h1234_5678, 1'b0, 1);
    tbl[4] = mk(1'b0, 32'h8000_0000, 32'h0, 32'h0F0F_0F0F,
                3, 32'h0F0F_0F0F, 1'b0, 4);

    repeat (3) @(negedge clk);
    chk("reset stb", {31'd0, STB_O}, 32'd0);
    chk("reset we", {31'd0, WE_O}, 32'd0);
    chk("reset adr", ADR_O, 32'd0);
    chk("reset dat", DAT_O, 32'd0);
    chk("reset rdata", cpu_rdata, 32'd0);
    chk("reset ready", {31'd0, cpu_ready}, 32'd0);
    chk("reset err", {31'd0, cpu_err}, 32'd0);
    chk("reset busy", {31'd0, cpu_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle no stb", {31'd0, STB_O}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Held request: accepted every third edge, never duplicated
    @(negedge clk);
    s0 = stb_total; r0 = rdy_total;
    cpu_req = 1'b1; cpu_we = 1'b1; slv_waits = 0;
    cpu_addr = 32'h0000_0100; cpu_wdata = 32'h0000_00AA;
    repeat (10) @(negedge clk);
    cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b ready count", rdy_total - r0, 32'd4);
    chk("b2b stb cycles", stb_total - s0, 32'd4);
    chk("b2b rdata kept", cpu_rdata, 32'h0F0F_0F0F);

`ifdef BUS_TIMEOUT_EN
    do_txn(mk(1'b0, 32'h0000_0200, 32'h0, 32'h7777_7777,
              100, 32'h0, 1'b1, 4), "timeout");
    do_txn(mk(1'b0, 32'h0000_0204, 32'h0, 32'h55AA_33CC,
              3, 32'h55AA_33CC, 1'b0, 4), "ack at expiry");
`else
    do_txn(mk(1'b0, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF,
              1000, 32'hDEAD_BEEF, 1'b0, 1001), "long wait");
`endif

    // Asynchronous reset while the slave is still stalling
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; slv_waits = 50;
    cpu_addr = 32'h0000_0400; cpu_wdata = 32'h0000_0099;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("mid stb before rst", {31'd0, STB_O}, 32'd1);
    r0 = rdy_total;
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst stb", {31'd0, STB_O}, 32'd0);
    chk("mid rst adr", ADR_O, 32'd0);
    chk("mid rst dat", DAT_O, 32'd0);
    chk("mid rst we", {31'd0, WE_O}, 32'd0);
    chk("mid rst busy", {31'd0, cpu_busy}, 32'd0);
    chk("mid rst rdata", cpu_rdata, 32'd0);
    chk("mid rst ready", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = stb_total;
    repeat (5) @(negedge clk);
    chk("post rst no ready", rdy_total - r0, 32'd0);
    chk("post rst no stb", stb_total - s0, 32'd0);
    do_txn(mk(1'b0, 32'h0000_0500, 32'h0, 32'h3C3C_3C3C,
              1, 32'h3C3C_3C3C, 1'b0, 2), "after rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
